// File: rtl/apb_i2c_pkg.sv
// apb_i2c_pkg: shared FSM state, register offsets and STATUS field positions for the APB/I2C register completer.
package apb_i2c_pkg;
    typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;
    localparam logic [1:0] REG_CTRL   = 2'd0;
    localparam logic [1:0] REG_STATUS = 2'd1;
    localparam logic [1:0] REG_TXDATA = 2'd2;
    localparam logic [1:0] REG_RXDATA = 2'd3;
    localparam int STAT_TX_LSB = 0;
    localparam int STAT_RX_LSB = 8;
    localparam int STAT_OVF    = 16;
endpackage

// File: rtl/apb_byte_fifo.sv
// apb_byte_fifo: byte FIFO; a pop in the same cycle frees a slot for a push into a full FIFO.
module apb_byte_fifo #(
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   push,
    input  logic                   pop,
    input  logic [7:0]             din,
    output logic [7:0]             dout,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    logic [7:0]    mem_q [DEPTH];
    logic [AW-1:0] wr_q, rd_q;
    logic [CW-1:0] cnt_q;
    logic          do_pop, do_push;
    assign empty   = cnt_q == '0;
    assign full    = cnt_q == CW'(DEPTH);
    assign count   = cnt_q;
    assign dout    = mem_q[rd_q];
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            if (do_push) begin
                mem_q[wr_q] <= din;
                wr_q        <= wr_q + 1'b1;
            end
            if (do_pop) rd_q <= rd_q + 1'b1;
            cnt_q <= cnt_q + CW'(do_push) - CW'(do_pop);
        end
    end
endmodule

// File: rtl/apb_i2c_regs_slave.sv
// apb_i2c_regs_slave: APB completer exposing CTRL/STATUS and TX/RX byte FIFOs to the I2C byte engine.
module apb_i2c_regs_slave
    import apb_i2c_pkg::*;
#(
    parameter logic [1:0] SLAVE_ID    = 2'd1,
    parameter int         ADDR_WIDTH  = 8,
    parameter int         DATA_WIDTH  = 32,
    parameter int         WAIT_STATES = 0,
    parameter int         FIFO_DEPTH  = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [1:0]            sel,
    input  logic                  enable,
    input  logic                  write,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic [DATA_WIDTH-1:0] wdata,
    output logic [DATA_WIDTH-1:0] rdata,
    output logic                  ready,
    output logic                  slverr,
    output logic [7:0]            ctrl,
    output logic [7:0]            tx_data,
    output logic                  tx_valid,
    input  logic                  tx_pop,
    input  logic [7:0]            rx_data,
    input  logic                  rx_push
);
    localparam int CW = $clog2(FIFO_DEPTH) + 1;
    state_t                state_q;
    logic [3:0]            cnt_q;
    logic                  wr_q, w1c_q, rx_ovf_q, ready_q, slverr_q;
    logic [1:0]            addr_q;
    logic [7:0]            wdata_q, ctrl_q, rx_dout;
    logic [DATA_WIDTH-1:0] rdata_q, status, rd_val;
    logic [CW-1:0]         tx_cnt, rx_cnt;
    logic                  setup, commit, tx_push, rx_pop, tx_full, tx_empty, rx_full, rx_empty;
    logic                  slverr_d, ovf_set, ovf_clr, unused_bits;
    assign unused_bits = ^{addr[ADDR_WIDTH-1:4], addr[1:0], wdata[DATA_WIDTH-1:17], wdata[15:8]};
    assign rdata    = rdata_q;
    assign ready    = ready_q;
    assign slverr   = slverr_q;
    assign ctrl     = ctrl_q;
    assign tx_valid = !tx_empty;
    assign setup    = sel == SLAVE_ID && !enable;
    assign commit   = state_q == WAIT && sel == SLAVE_ID && enable && cnt_q == '0;
    assign tx_push  = commit && wr_q && addr_q == REG_TXDATA;
    assign rx_pop   = commit && !wr_q && addr_q == REG_RXDATA;
    assign ovf_set  = rx_push && rx_full && !(rx_pop && !rx_empty);
    assign ovf_clr  = commit && wr_q && addr_q == REG_STATUS && w1c_q;
    always_comb begin
        status = '0;
        status[STAT_TX_LSB +: CW] = tx_cnt;
        status[STAT_RX_LSB +: CW] = rx_cnt;
        status[STAT_OVF] = rx_ovf_q;
        rd_val = addr_q == REG_CTRL   ? DATA_WIDTH'(ctrl_q) :
                 addr_q == REG_STATUS ? status :
                 addr_q == REG_RXDATA && !rx_empty ? DATA_WIDTH'(rx_dout) : '0;
        slverr_d = wr_q ? (addr_q == REG_RXDATA || (addr_q == REG_TXDATA && tx_full && !(tx_pop && !tx_empty)))
                        : (addr_q == REG_TXDATA || (addr_q == REG_RXDATA && rx_empty));
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            wr_q     <= 1'b0;
            w1c_q    <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= '0;
            ctrl_q   <= '0;
            rx_ovf_q <= 1'b0;
            ready_q  <= 1'b0;
            slverr_q <= 1'b0;
            rdata_q  <= '0;
        end else begin
            ready_q  <= commit;
            rx_ovf_q <= ovf_set || (rx_ovf_q && !ovf_clr);
            if (commit) begin
                slverr_q <= slverr_d;
                if (!wr_q) rdata_q <= rd_val;
                if (wr_q && addr_q == REG_CTRL) ctrl_q <= wdata_q;
            end
            case (state_q)
                WAIT: begin
                    if (sel != SLAVE_ID) state_q <= IDLE;
                    else if (enable) begin
                        if (cnt_q == '0) state_q <= DONE;
                        else cnt_q <= cnt_q - 1'b1;
                    end
                end
                default: begin
                    state_q <= setup ? WAIT : IDLE;
                    if (setup) begin
                        wr_q    <= write;
                        addr_q  <= addr[3:2];
                        wdata_q <= wdata[7:0];
                        w1c_q   <= wdata[STAT_OVF];
                        cnt_q   <= 4'(WAIT_STATES);
                    end
                end
            endcase
        end
    end
    apb_byte_fifo #(.DEPTH(FIFO_DEPTH)) u_tx (
        .clk(clk), .reset(reset), .push(tx_push), .pop(tx_pop), .din(wdata_q),
        .dout(tx_data), .full(tx_full), .empty(tx_empty), .count(tx_cnt)
    );
    apb_byte_fifo #(.DEPTH(FIFO_DEPTH)) u_rx (
        .clk(clk), .reset(reset), .push(rx_push), .pop(rx_pop), .din(rx_data),
        .dout(rx_dout), .full(rx_full), .empty(rx_empty), .count(rx_cnt)
    );
endmodule

// File: tb/tb_apb_i2c_regs_slave.sv
// tb_apb_i2c_regs_slave: directed vector table plus hand sequences over three instances with 0, 2 and 3 wait states.
module tb_apb_i2c_regs_slave;
    logic        clk = 1'b0, reset, enable, write, nz;
    logic [7:0]  addr, rx_data;
    logic [31:0] wdata;
    logic        tx_pop, rx_push;
    logic [1:0]  sel_v [3];
    logic [31:0] rdata_v [3];
    logic        ready_v [3], slverr_v [3], tx_valid_v [3];
    logic [7:0]  ctrl_v [3], tx_data_v [3];
    int          total = 0, bad = 0;

    always #5 clk = ~clk;

    apb_i2c_regs_slave #(.WAIT_STATES(0)) dut0 (
        .clk(clk), .reset(reset), .sel(sel_v[0]), .enable(enable), .write(write), .addr(addr), .wdata(wdata),
        .rdata(rdata_v[0]), .ready(ready_v[0]), .slverr(slverr_v[0]), .ctrl(ctrl_v[0]), .tx_data(tx_data_v[0]),
        .tx_valid(tx_valid_v[0]), .tx_pop(tx_pop), .rx_data(rx_data), .rx_push(rx_push));
    apb_i2c_regs_slave #(.WAIT_STATES(2)) dut2 (
        .clk(clk), .reset(reset), .sel(sel_v[1]), .enable(enable), .write(write), .addr(addr), .wdata(wdata),
        .rdata(rdata_v[1]), .ready(ready_v[1]), .slverr(slverr_v[1]), .ctrl(ctrl_v[1]), .tx_data(tx_data_v[1]),
        .tx_valid(tx_valid_v[1]), .tx_pop(nz), .rx_data(8'h00), .rx_push(nz));
    apb_i2c_regs_slave #(.WAIT_STATES(3)) dut3 (
        .clk(clk), .reset(reset), .sel(sel_v[2]), .enable(enable), .write(write), .addr(addr), .wdata(wdata),
        .rdata(rdata_v[2]), .ready(ready_v[2]), .slverr(slverr_v[2]), .ctrl(ctrl_v[2]), .tx_data(tx_data_v[2]),
        .tx_valid(tx_valid_v[2]), .tx_pop(nz), .rx_data(8'h00), .rx_push(nz));

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic xfer(input int d, input logic w, input logic [7:0] a, input logic [31:0] wd,
                        input logic rxp, input logic [7:0] rxb,
                        output logic [31:0] rd, output logic err, output int waits);
        @(negedge clk);
        sel_v[d] = 2'd1; enable = 1'b0; write = w; addr = a; wdata = wd;
        @(negedge clk);
        enable = 1'b1;
        if (rxp) begin rx_push = 1'b1; rx_data = rxb; end
        waits = 0;
        @(negedge clk);
        rx_push = 1'b0;
        while (!ready_v[d] && waits < 40) begin
            waits++;
            @(negedge clk);
        end
        rd = rdata_v[d]; err = slverr_v[d];
        sel_v[d] = 2'd0; enable = 1'b0;
    endtask

    typedef struct {
        logic        w;
        logic [7:0]  a;
        logic [31:0] wd;
        logic        chk_rd;
        logic [31:0] exp_rd;
        logic        exp_err;
    } vec_t;

    initial begin
        vec_t        tbl [14];
        logic [31:0] rd;
        logic        err;
        int          waits;
        logic [7:0]  exp_b [4];
        reset = 1'b1; enable = 1'b0; write = 1'b0; addr = '0; wdata = '0; nz = 1'b0;
        tx_pop = 1'b0; rx_push = 1'b0; rx_data = '0;
        for (int i = 0; i < 3; i++) sel_v[i] = 2'd0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check("reset_ready", 32'(ready_v[0]), 0);
        check("reset_slverr", 32'(slverr_v[0]), 0);
        check("reset_rdata", rdata_v[0], 0);
        check("reset_ctrl", 32'(ctrl_v[0]), 0);
        check("reset_tx_valid", 32'(tx_valid_v[0]), 0);

        tbl[0]  = '{1'b1, 8'h00, 32'hA5,    1'b0, 32'h0,    1'b0};
        tbl[1]  = '{1'b0, 8'h00, 32'h0,     1'b1, 32'hA5,   1'b0};
        tbl[2]  = '{1'b0, 8'h04, 32'h0,     1'b1, 32'h0,    1'b0};
        tbl[3]  = '{1'b1, 8'h08, 32'h11,    1'b0, 32'h0,    1'b0};
        tbl[4]  = '{1'b1, 8'h09, 32'h22,    1'b0, 32'h0,    1'b0};
        tbl[5]  = '{1'b1, 8'h0A, 32'h33,    1'b0, 32'h0,    1'b0};
        tbl[6]  = '{1'b1, 8'h0B, 32'h44,    1'b0, 32'h0,    1'b0};
        tbl[7]  = '{1'b1, 8'h08, 32'h55,    1'b0, 32'h0,    1'b1};
        tbl[8]  = '{1'b0, 8'h04, 32'h0,     1'b1, 32'h4,    1'b0};
        tbl[9]  = '{1'b0, 8'h08, 32'h0,     1'b0, 32'h0,    1'b1};
        tbl[10] = '{1'b1, 8'h0C, 32'h99,    1'b0, 32'h0,    1'b1};
        tbl[11] = '{1'b0, 8'h0C, 32'h0,     1'b1, 32'h0,    1'b1};
        tbl[12] = '{1'b1, 8'h10, 32'h3C,    1'b0, 32'h0,    1'b0};
        tbl[13] = '{1'b0, 8'h00, 32'h0,     1'b1, 32'h3C,   1'b0};
        for (int i = 0; i < 14; i++) begin
            xfer(0, tbl[i].w, tbl[i].a, tbl[i].wd, 1'b0, 8'h00, rd, err, waits);
            check($sformatf("vec%0d_waits", i), waits, 0);
            check($sformatf("vec%0d_slverr", i), 32'(err), 32'(tbl[i].exp_err));
            if (tbl[i].chk_rd) check($sformatf("vec%0d_rdata", i), rd, tbl[i].exp_rd);
            if (i == 0) check("ctrl_after_write", 32'(ctrl_v[0]), 32'hA5);
            if (i == 0) begin
                @(negedge clk);
                check("ready_one_cycle", 32'(ready_v[0]), 0);
            end
        end
        check("ctrl_final", 32'(ctrl_v[0]), 32'h3C);

        exp_b[0] = 8'h11; exp_b[1] = 8'h22; exp_b[2] = 8'h33; exp_b[3] = 8'h44;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            tx_pop = 1'b0;
            check($sformatf("tx_valid%0d", i), 32'(tx_valid_v[0]), 1);
            check($sformatf("tx_data%0d", i), 32'(tx_data_v[0]), 32'(exp_b[i]));
            tx_pop = 1'b1;
        end
        @(negedge clk);
        tx_pop = 1'b0;
        check("tx_drained", 32'(tx_valid_v[0]), 0);

        for (int i = 1; i <= 5; i++) begin
            @(negedge clk);
            rx_push = 1'b1; rx_data = 8'(i);
        end
        @(negedge clk);
        rx_push = 1'b0;
        xfer(0, 1'b0, 8'h04, 0, 1'b0, 8'h00, rd, err, waits);
        check("status_ovf", rd, 32'h0001_0400);
        xfer(0, 1'b1, 8'h04, 32'h0001_0000, 1'b0, 8'h00, rd, err, waits);
        check("w1c_slverr", 32'(err), 0);
        xfer(0, 1'b0, 8'h04, 0, 1'b0, 8'h00, rd, err, waits);
        check("status_cleared", rd, 32'h0000_0400);
        for (int i = 1; i <= 5; i++) begin
            xfer(0, 1'b0, 8'h0C, 0, 1'b0, 8'h00, rd, err, waits);
            check($sformatf("rx_read%0d", i), rd, i == 5 ? 32'h0 : 32'(i));
            check($sformatf("rx_err%0d", i), 32'(err), i == 5 ? 32'h1 : 32'h0);
        end

        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            rx_push = 1'b1; rx_data = 8'hA1 + 8'(i);
        end
        @(negedge clk);
        rx_push = 1'b0;
        xfer(0, 1'b0, 8'h0C, 0, 1'b1, 8'hA5, rd, err, waits);
        check("pop_push_rd", rd, 32'hA1);
        check("pop_push_err", 32'(err), 0);
        xfer(0, 1'b0, 8'h04, 0, 1'b0, 8'h00, rd, err, waits);
        check("pop_push_status", rd, 32'h0000_0400);
        for (int i = 0; i < 4; i++) begin
            xfer(0, 1'b0, 8'h0C, 0, 1'b0, 8'h00, rd, err, waits);
            check($sformatf("pop_push_order%0d", i), rd, 32'hA2 + 32'(i));
        end

        xfer(2, 1'b0, 8'h04, 0, 1'b0, 8'h00, rd, err, waits);
        check("ws3_waits", waits, 3);
        check("ws3_rdata", rd, 0);
        check("ws3_slverr", 32'(err), 0);
        xfer(2, 1'b1, 8'h00, 32'h5A, 1'b0, 8'h00, rd, err, waits);
        xfer(2, 1'b0, 8'h00, 0, 1'b0, 8'h00, rd, err, waits);
        check("ws3_ctrl_rd", rd, 32'h5A);

        @(negedge clk);
        sel_v[1] = 2'd1; write = 1'b1; addr = 8'h08; wdata = 32'h66;
        @(negedge clk);
        enable = 1'b1;
        @(negedge clk);
        sel_v[1] = 2'd0; enable = 1'b0;
        begin
            int seen = 0;
            repeat (4) begin
                @(negedge clk);
                if (ready_v[1]) seen++;
            end
            check("abort_no_ready", seen, 0);
        end
        check("abort_tx_valid", 32'(tx_valid_v[1]), 0);
        xfer(1, 1'b0, 8'h04, 0, 1'b0, 8'h00, rd, err, waits);
        check("abort_next_waits", waits, 2);
        check("abort_status", rd, 0);

        @(negedge clk);
        sel_v[0] = 2'd1; write = 1'b1; addr = 8'h08; wdata = 32'h77;
        @(negedge clk);
        enable = 1'b1; reset = 1'b1;
        @(negedge clk);
        reset = 1'b0; sel_v[0] = 2'd0; enable = 1'b0;
        check("midreset_ready", 32'(ready_v[0]), 0);
        check("midreset_tx_valid", 32'(tx_valid_v[0]), 0);
        check("midreset_ctrl", 32'(ctrl_v[0]), 0);
        @(negedge clk);
        check("midreset_no_late_ready", 32'(ready_v[0]), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
